timer_digit_loader: RTL and testbench
=====================================

TIMER_DIGIT_LOADER -- requirements
Module: timer_digit_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable samples needed to accept a key press or a key release (legal range 2..15).
REQ-002 clock  input  1  single system clock; all state updates on the rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 D  input  4  BCD key code from the keypad priority encoder, valid while key_valid=1.
REQ-005 key_valid  input  1  high while any keypad key is held.
REQ-006 enablen  input  1  active-low entry enable; 1 means key presses are ignored.
REQ-007 clear  input  1  synchronous active-high clear of the entered digits.
REQ-008 sec_ones, sec_tens, min_ones, min_tens  output  4 each  entered timer digits in MM:SS order.
REQ-009 digit_count  output  3  number of digits entered so far (0..4).
REQ-010 full  output  1  high when digit_count=4.
REQ-011 new_digit  output  1  one-cycle pulse on each accepted digit.
REQ-012 err_digit  output  1  one-cycle pulse on each press rejected because D>9.

Function
REQ-013 FSM states: IDLE, DEBOUNCE, HELD, RELEASE; a 4-bit counter cnt serves both debounce phases.
REQ-014 IDLE: enablen=0 and key_valid=1 -> DEBOUNCE, cnt=1; otherwise stay.
REQ-015 DEBOUNCE: key_valid=0 or enablen=1 -> IDLE, cnt=0; key_valid=1 and cnt<DEBOUNCE_CYCLES -> cnt+1; key_valid=1 and cnt=DEBOUNCE_CYCLES -> HELD and press processed on that same edge.
REQ-016 Latency: with edge 1 the first to sample key_valid=1, press processing happens at edge DEBOUNCE_CYCLES+1 (edge 5 at default).
REQ-017 Press processing, D<=9 and full=0: shift left (min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D), digit_count+1, new_digit=1 next cycle.
REQ-018 Press processing, D>9: no shift, count unchanged, err_digit=1 next cycle.
REQ-019 Press processing, full=1: press consumed silently; no shift, no new_digit, no err_digit.
REQ-020 HELD: key_valid=0 -> RELEASE, cnt=1; otherwise stay (auto-repeat is not supported).
REQ-021 RELEASE: key_valid=1 -> HELD, cnt=0; key_valid=0 and cnt<DEBOUNCE_CYCLES -> cnt+1; cnt=DEBOUNCE_CYCLES -> IDLE.
REQ-022 D is sampled only on the processing edge; D changes at any other time have no effect.
REQ-023 clear=1: all digits 0, digit_count 0 next edge; FSM state unaffected.
REQ-024 clear and press processing on the same edge: clear wins, no shift, new_digit and err_digit stay 0.
REQ-025 enablen=1 in HELD or RELEASE does not abort release tracking; a new press is only accepted after IDLE is reached.
REQ-026 new_digit and err_digit are registered, never high simultaneously, never high two consecutive cycles.

Reset
REQ-027 resetn=0 asynchronously forces state IDLE, cnt 0, all digits 0, digit_count 0, full 0, new_digit 0, err_digit 0.
REQ-028 Reset asserted mid-debounce or mid-hold discards the press; after release the FSM starts from IDLE and a key still held is debounced as a new press.

Structure
REQ-029 Shared package holds BCD_W=4, MAX_DIGIT=9, NUM_DIGITS=4 and the FSM state encoding.
REQ-030 One sub-module, key_debouncer, implements the FSM and cnt and outputs a one-cycle press_accept strobe; the top holds the digit shift register, count and pulse logic.

Verification
REQ-031 Reset, enablen=0, key_valid=1 with D=5 for 10 cycles -> at edge 5 sec_ones=5, digit_count=1, new_digit high exactly one cycle.
REQ-032 Presses D=1,2,3,0 each with debounced release -> min_tens=1, min_ones=2, sec_tens=3, sec_ones=0, full=1; fifth press D=7 -> digits unchanged, no pulse.
REQ-033 key_valid glitch high for 3 cycles (DEBOUNCE_CYCLES=4) -> no digit change, FSM back in IDLE; release bounce of 2 cycles while HELD -> no second digit.
REQ-034 Press with D=12 -> err_digit one-cycle pulse, digits and digit_count unchanged.
REQ-035 clear asserted on the processing edge of a D=8 press -> all digits 0, digit_count 0, new_digit stays 0.
REQ-036 resetn pulsed low at cycle 3 of a debounce with key held -> outputs 0 immediately; after release, digit accepted DEBOUNCE_CYCLES+1 edges later.

Source files
------------

// File: rtl/timer_digit_loader_pkg.sv
// Shared constants and debouncer state encoding for the timer digit loader.
package timer_digit_loader_pkg;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGIT  = 9;
    localparam int NUM_DIGITS = 4;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } kd_state_t;

endpackage

// File: rtl/key_debouncer.sv
// Keypad press/release debouncer; emits a one-cycle press_accept strobe.
//   state       | meaning
//   ST_IDLE     | waiting for an enabled key press
//   ST_DEBOUNCE | key seen, counting stable high samples
//   ST_HELD     | press accepted, waiting for key release
//   ST_RELEASE  | key low, counting stable low samples
module key_debouncer
    import timer_digit_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic resetn,
    input  logic key_valid,
    input  logic enablen,
    output logic press_accept
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

    kd_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        press_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!enablen && key_valid) begin
                    state_d = ST_DEBOUNCE;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (!key_valid || enablen) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d      = ST_HELD;
                    cnt_d        = '0;
                    press_accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                // enablen is deliberately ignored until the key is released
                if (!key_valid) begin
                    state_d = ST_RELEASE;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (key_valid) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/timer_digit_loader.sv
// Loads debounced keypad digits into an MM:SS shift register with count and pulses.
module timer_digit_loader
    import timer_digit_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [BCD_W-1:0] D,
    input  logic             key_valid,
    input  logic             enablen,
    input  logic             clear,
    output logic [BCD_W-1:0] sec_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] min_tens,
    output logic [2:0]       digit_count,
    output logic             full,
    output logic             new_digit,
    output logic             err_digit
);

    logic press_accept;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clock       (clock),
        .resetn      (resetn),
        .key_valid   (key_valid),
        .enablen     (enablen),
        .press_accept(press_accept)
    );

    assign full = (digit_count == 3'(NUM_DIGITS));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sec_ones    <= '0;
            sec_tens    <= '0;
            min_ones    <= '0;
            min_tens    <= '0;
            digit_count <= '0;
            new_digit   <= 1'b0;
            err_digit   <= 1'b0;
        end else begin
            new_digit <= 1'b0;
            err_digit <= 1'b0;
            // clear overrides a press landing on the same edge
            if (clear) begin
                sec_ones    <= '0;
                sec_tens    <= '0;
                min_ones    <= '0;
                min_tens    <= '0;
                digit_count <= '0;
            end else if (press_accept && !full) begin
                if (D > BCD_W'(MAX_DIGIT)) begin
                    err_digit <= 1'b1;
                end else begin
                    min_tens    <= min_ones;
                    min_ones    <= sec_tens;
                    sec_tens    <= sec_ones;
                    sec_ones    <= D;
                    digit_count <= digit_count + 3'd1;
                    new_digit   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_digit_loader.sv
// Self-checking bench: table vectors, directed corner sequences and a random run vs a run-length model.
module tb_timer_digit_loader;

    localparam int N = 4;

    logic       clock;
    logic       resetn;
    logic [3:0] d;
    logic       key_valid;
    logic       enablen;
    logic       clear;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic [2:0] digit_count;
    logic       full, new_digit, err_digit;

    timer_digit_loader #(.DEBOUNCE_CYCLES(N)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .D          (d),
        .key_valid  (key_valid),
        .enablen    (enablen),
        .clear      (clear),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .digit_count(digit_count),
        .full       (full),
        .new_digit  (new_digit),
        .err_digit  (err_digit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    // Model: digits[0]=sec_ones .. digits[3]=min_tens; key tracked as run lengths.
    logic [3:0] m_dig [4];
    int         m_cnt;
    logic       m_new, m_err;
    bit         m_armed;
    int         m_run;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [21:0] dut_vec();
        return {min_tens, min_ones, sec_tens, sec_ones, digit_count, full, new_digit, err_digit};
    endfunction

    function automatic logic [21:0] model_vec();
        return {m_dig[3], m_dig[2], m_dig[1], m_dig[0], 3'(m_cnt), (m_cnt == 4), m_new, m_err};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
        m_cnt = 0; m_new = 0; m_err = 0; m_armed = 1; m_run = 0;
    endtask

    task automatic model_step();
        bit accept;
        accept = 0;
        m_new  = 0;
        m_err  = 0;
        // A press needs N+1 consecutive enabled-high samples; re-arming needs N+1 low samples.
        if (m_armed) begin
            if (key_valid && !enablen) begin
                m_run++;
                if (m_run == N + 1) begin accept = 1; m_armed = 0; m_run = 0; end
            end else m_run = 0;
        end else begin
            if (!key_valid) begin
                m_run++;
                if (m_run == N + 1) begin m_armed = 1; m_run = 0; end
            end else m_run = 0;
        end
        if (clear) begin
            for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
            m_cnt = 0;
        end else if (accept && m_cnt < 4) begin
            if (d > 9) m_err = 1;
            else begin
                for (int i = 3; i > 0; i--) m_dig[i] = m_dig[i-1];
                m_dig[0] = d;
                m_cnt++;
                m_new = 1;
            end
        end
    endtask

    task automatic cycle(input logic kv, input logic [3:0] dd, input logic en, input logic clr);
        key_valid = kv; d = dd; enablen = en; clear = clr;
        @(posedge clock);
        model_step();
        @(negedge clock);
        pulses += int'(new_digit) + int'(err_digit);
        check("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic reset_pulse();
        resetn = 1'b0;
        #1;
        model_reset();
        check("async_reset", 32'(dut_vec()), 32'd0);
        #1 resetn = 1'b1;
    endtask

    task automatic press(input logic [3:0] dd);
        for (int i = 0; i < N + 2; i++) cycle(1'b1, dd, 1'b0, 1'b0);
        for (int i = 0; i < N + 2; i++) cycle(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic       kv;
        logic [3:0] dd;
        logic [3:0] exp_so;
        logic [2:0] exp_cnt;
        logic       exp_new;
    } vec_t;

    vec_t tbl [16];
    int   p0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i].kv      = (i < 10);
            tbl[i].dd      = (i < 10) ? 4'd5 : 4'd0;
            tbl[i].exp_so  = (i < 4) ? 4'd0 : 4'd5;
            tbl[i].exp_cnt = (i < 4) ? 3'd0 : 3'd1;
            tbl[i].exp_new = (i == 4);
        end

        resetn = 1'b0; key_valid = 1'b0; d = 4'd0; enablen = 1'b0; clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_state", 32'(dut_vec()), 32'd0);
        resetn = 1'b1;

        // Single press D=5 held 10 cycles, then released
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].kv, tbl[i].dd, 1'b0, 1'b0);
            check($sformatf("tbl[%0d]", i), {23'd0, sec_ones, digit_count, new_digit, err_digit},
                  {23'd0, tbl[i].exp_so, tbl[i].exp_cnt, tbl[i].exp_new, 1'b0});
        end

        // Fill all four digits, then a fifth press is swallowed
        reset_pulse();
        press(4'd1); press(4'd2); press(4'd3); press(4'd0);
        check("fill_digits", {16'd0, min_tens, min_ones, sec_tens, sec_ones}, 32'h1230);
        check("fill_full", {31'd0, full}, 32'd1);
        p0 = pulses;
        press(4'd7);
        check("full_no_pulse", 32'(pulses - p0), 32'd0);
        check("full_digits", {16'd0, min_tens, min_ones, sec_tens, sec_ones}, 32'h1230);

        // Short glitch rejected, then a real press and release bounce
        reset_pulse();
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'd4, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'd4, 1'b0, 1'b0);
        check("glitch_cnt", 32'(digit_count), 32'd0);
        for (int i = 0; i < N; i++) cycle(1'b1, 4'd4, 1'b0, 1'b0);
        check("press_not_yet", 32'(digit_count), 32'd0);
        cycle(1'b1, 4'd4, 1'b0, 1'b0);
        check("press_edge", {24'd0, sec_ones, digit_count, new_digit}, {24'd0, 4'd4, 3'd1, 1'b1});
        cycle(1'b1, 4'd9, 1'b0, 1'b0);
        cycle(1'b1, 4'd9, 1'b1, 1'b0);
        p0 = pulses;
        for (int i = 0; i < 2; i++) cycle(1'b0, 4'd9, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'd9, 1'b0, 1'b0);
        for (int i = 0; i < N + 2; i++) cycle(1'b0, 4'd9, 1'b0, 1'b0);
        check("bounce_no_digit", {24'd0, sec_ones, digit_count, 1'b0}, {24'd0, 4'd4, 3'd1, 1'b0});
        check("bounce_no_pulse", 32'(pulses - p0), 32'd0);

        // Out-of-range key produces an error pulse only
        for (int i = 0; i < N; i++) cycle(1'b1, 4'd12, 1'b0, 1'b0);
        cycle(1'b1, 4'd12, 1'b0, 1'b0);
        check("err_pulse", {28'd0, sec_ones[0], digit_count[0], new_digit, err_digit}, 32'h4 | 32'h0 | 32'h1);
        cycle(1'b1, 4'd12, 1'b0, 1'b0);
        check("err_one_cycle", {30'd0, new_digit, err_digit}, 32'd0);
        check("err_digits", {21'd0, min_tens, min_ones, sec_ones, digit_count[0]}, {21'd0, 4'd0, 4'd0, 4'd4, 1'b1});
        for (int i = 0; i < N + 2; i++) cycle(1'b0, 4'd0, 1'b0, 1'b0);

        // Clear lands on the processing edge of a D=8 press
        for (int i = 0; i < N; i++) cycle(1'b1, 4'd8, 1'b0, 1'b0);
        cycle(1'b1, 4'd8, 1'b0, 1'b1);
        check("clear_wins", 32'(dut_vec()), 32'd0);
        cycle(1'b1, 4'd8, 1'b0, 1'b0);
        check("clear_no_pulse", {30'd0, new_digit, err_digit}, 32'd0);
        for (int i = 0; i < N + 2; i++) cycle(1'b0, 4'd0, 1'b0, 1'b0);

        // Reset in the middle of a debounce with the key still held
        press(4'd3);
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'd6, 1'b0, 1'b0);
        reset_pulse();
        for (int i = 0; i < N; i++) cycle(1'b1, 4'd6, 1'b0, 1'b0);
        check("rst_not_yet", 32'(digit_count), 32'd0);
        cycle(1'b1, 4'd6, 1'b0, 1'b0);
        check("rst_repress", {24'd0, sec_ones, digit_count, new_digit}, {24'd0, 4'd6, 3'd1, 1'b1});
        for (int i = 0; i < N + 2; i++) cycle(1'b0, 4'd0, 1'b0, 1'b0);

        // Random key activity checked against the model
        for (int seg = 0; seg < 400; seg++) begin
            logic kv;
            int   len;
            kv  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                cycle(kv, 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 59) == 0));
                if (new_digit && err_digit) check("pulse_exclusive", 32'd1, 32'd0);
            end
            if ($urandom_range(0, 99) == 0) reset_pulse();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
